// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache line mover: FSM encoding, default line
// geometry and helpers for building BRAM word addresses from line + word index.
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WB    = 2'd1,
        ST_FILL  = 2'd2,
        ST_DRAIN = 2'd3
    } mover_state_e;

    localparam int unsigned DEFAULT_WORDS_PER_LINE = 4;

    function automatic int unsigned line_idx_width(input int unsigned words);
        return $clog2(words);
    endfunction

    // Word address is {line, idx}; callers truncate to their address width.
    function automatic logic [31:0] line_word_addr(input logic [31:0] line,
                                                   input logic [31:0] idx,
                                                   input int unsigned idx_w);
        return (line << idx_w) | idx;
    endfunction

endpackage

// File: rtl/dcache_line_mover.sv
// Line-transfer engine between the cache controller and BRAM port A: optional
// dirty-victim write-back followed by a streamed line fill into the cache.
module dcache_line_mover
    import dcache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 11,
    parameter int unsigned NUM_COL         = 4,
    parameter int unsigned COL_WIDTH       = 8,
    parameter int unsigned WORDS_PER_LINE  = DEFAULT_WORDS_PER_LINE,
    parameter int unsigned DATA_WIDTH      = NUM_COL * COL_WIDTH,
    parameter int unsigned LINE_ADDR_WIDTH = ADDR_WIDTH - $clog2(WORDS_PER_LINE)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic                                 req_wb,
    input  logic [LINE_ADDR_WIDTH-1:0]           req_wb_line,
    input  logic [LINE_ADDR_WIDTH-1:0]           req_fill_line,
    input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] req_wb_data,
    output logic                                 fill_we,
    output logic [$clog2(WORDS_PER_LINE)-1:0]    fill_idx,
    output logic [DATA_WIDTH-1:0]                fill_word,
    output logic                                 done,
    output logic                                 mem_en,
    output logic [NUM_COL-1:0]                   mem_we,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [DATA_WIDTH-1:0]                mem_din,
    input  logic [DATA_WIDTH-1:0]                mem_dout
);

    localparam int unsigned      IDX_W    = line_idx_width(WORDS_PER_LINE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

    mover_state_e                         state_q, state_d;
    logic [IDX_W-1:0]                     cnt_q, cnt_d;
    logic [LINE_ADDR_WIDTH-1:0]           wb_line_q, wb_line_d;
    logic [LINE_ADDR_WIDTH-1:0]           fill_line_q, fill_line_d;
    logic [DATA_WIDTH*WORDS_PER_LINE-1:0] wb_data_q, wb_data_d;
    logic                                 rd_pending_q, rd_pending_d;
    logic [IDX_W-1:0]                     rd_idx_q, rd_idx_d;
    logic                                 mem_en_q, mem_en_d;
    logic [NUM_COL-1:0]                   mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]                mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]                mem_din_q, mem_din_d;
    logic                                 accept;

    assign accept = req_valid && (state_q == ST_IDLE);

    // State register and control/BRAM-port registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rd_pending_q <= 1'b0;
            rd_idx_q     <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= '0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_pending_q <= rd_pending_d;
            rd_idx_q     <= rd_idx_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
        end
    end

    // NOTE: the request capture registers carry no reset; they are only read
    // after an accept has loaded them, so resetting the wide data is wasted.
    always_ff @(posedge clk) begin
        wb_line_q   <= wb_line_d;
        fill_line_q <= fill_line_d;
        wb_data_q   <= wb_data_d;
    end

    // Next-state logic.
    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wb_line_d   = wb_line_q;
        fill_line_d = fill_line_q;
        wb_data_d   = wb_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wb_line_d   = req_wb_line;
                    fill_line_d = req_fill_line;
                    wb_data_d   = req_wb_data;
                    cnt_d       = '0;
                    state_d     = req_wb ? ST_WB : ST_FILL;
                end
            end
            ST_WB: begin
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = ST_FILL;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            ST_FILL: begin
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic: BRAM port values are precomputed from the next state so the
    // registered port lines up with the state it belongs to.
    always_comb begin
        mem_en_d     = 1'b0;
        mem_we_d     = '0;
        mem_addr_d   = '0;
        mem_din_d    = '0;
        rd_pending_d = (state_q == ST_FILL);
        rd_idx_d     = cnt_q;
        case (state_d)
            ST_WB: begin
                mem_en_d   = 1'b1;
                mem_we_d   = {NUM_COL{1'b1}};
                mem_addr_d = ADDR_WIDTH'(line_word_addr(32'(wb_line_d), 32'(cnt_d), IDX_W));
                mem_din_d  = wb_data_d[cnt_d*DATA_WIDTH +: DATA_WIDTH];
            end
            ST_FILL: begin
                mem_en_d   = 1'b1;
                mem_addr_d = ADDR_WIDTH'(line_word_addr(32'(fill_line_d), 32'(cnt_d), IDX_W));
            end
            default: ;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DRAIN);
    assign fill_we   = rd_pending_q;
    assign fill_idx  = rd_pending_q ? rd_idx_q : '0;
    assign fill_word = rd_pending_q ? mem_dout : '0;

    // Reset aborts an in-flight write in its own cycle, not one edge later.
    assign mem_en   = mem_en_q & ~rst;
    assign mem_we   = mem_we_q & {NUM_COL{~rst}};
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule
